// File: rtl/sum_accumulator.sv
// sum_accumulator: collects N_SAMPLES unsigned sums from the adder stage.
// It then presents the batch total, with a per-batch overflow flag, on a
// registered valid/ready output port.
// Optional feature macro: SUM_ACC_SAT_EN. When it is defined, the accumulator
// clamps at 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
module sum_accumulator #(
    parameter int IN_W      = 5,
    parameter int ACC_W     = 12,
    parameter int N_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_acc;
    logic               r_out_ovf;

    logic [ACC_W:0]     w_sum_full;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_accept;
    logic               w_last;

    // One extra bit on the adder so the carry out of the accumulator is visible.
    assign w_sum_full = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
    assign w_carry    = w_sum_full[ACC_W];

`ifdef SUM_ACC_SAT_EN
    // Clamp to all-ones on carry; once clamped, any further nonzero add carries again.
    function automatic logic [ACC_W-1:0] f_sat(input logic [ACC_W:0] s);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign w_acc_next = f_sat(w_sum_full);
`else
    assign w_acc_next = w_sum_full[ACC_W-1:0];
`endif

    // Ready is a pure decode of the state register, independent of in_valid/out_ready.
    assign in_ready = (r_state == ACCUM);
    assign w_accept = in_valid && (r_state == ACCUM);
    assign w_last   = (r_cnt == CNT_W'(N_SAMPLES - 1));

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

    // Batch FSM: accumulate in ACCUM, hold the registered result in HOLD until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            // Flush: drop the partial batch and any pending result; out_acc keeps its value.
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_acc   <= w_acc_next;
                            r_out_ovf   <= r_ovf | w_carry;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                            r_state     <= HOLD;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_ovf <= r_ovf | w_carry;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator. It runs two instances on shared stimulus: the default
// build (ACC_W=12) and a narrow one (ACC_W=6) that makes overflow reachable. Both are
// compared every cycle against a batch-level reference model.
module tb_sum_accumulator;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_sum;
    logic        clear;
    logic        out_ready;

    logic        in_ready12, out_valid12, out_ovf12;
    logic [11:0] out_acc12;
    logic        in_ready6, out_valid6, out_ovf6;
    logic [5:0]  out_acc6;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of accepted samples in the current batch plus the published result.
    int   m_q[$];
    bit   m_hold;
    bit   m_valid;
    int   m_acc12, m_acc6;
    bit   m_ovf12, m_ovf6;

    sum_accumulator #(.IN_W(5), .ACC_W(12), .N_SAMPLES(N)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
        .in_sum(in_sum), .clear(clear), .out_valid(out_valid12),
        .out_ready(out_ready), .out_acc(out_acc12), .out_ovf(out_ovf12)
    );

    sum_accumulator #(.IN_W(5), .ACC_W(6), .N_SAMPLES(N)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in_sum(in_sum), .clear(clear), .out_valid(out_valid6),
        .out_ready(out_ready), .out_acc(out_acc6), .out_ovf(out_ovf6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Batch result for a given accumulator width, from the plain arithmetic total.
    task automatic batch_result(input int total, input int w, output int acc, output bit ovf);
        int lim;
        lim = 1 << w;
        ovf = (total >= lim);
`ifdef SUM_ACC_SAT_EN
        acc = (total >= lim) ? lim - 1 : total;
`else
        acc = total % lim;
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold  = 1'b0;
        m_valid = 1'b0;
        m_acc12 = 0;
        m_acc6  = 0;
        m_ovf12 = 1'b0;
        m_ovf6  = 1'b0;
    endtask

    task automatic model_edge(input bit iv, input int s, input bit clr, input bit ordy);
        int total;
        if (clr) begin
            m_q.delete();
            m_hold  = 1'b0;
            m_valid = 1'b0;
        end else if (!m_hold) begin
            if (iv) begin
                m_q.push_back(s);
                if (m_q.size() == N) begin
                    total = 0;
                    foreach (m_q[i]) total += m_q[i];
                    batch_result(total, 12, m_acc12, m_ovf12);
                    batch_result(total, 6, m_acc6, m_ovf6);
                    m_valid = 1'b1;
                    m_hold  = 1'b1;
                    m_q.delete();
                end
            end
        end else if (ordy) begin
            m_valid = 1'b0;
            m_hold  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready12"},  32'(in_ready12),  32'(!m_hold));
        chk({tag, ".out_valid12"}, 32'(out_valid12), 32'(m_valid));
        chk({tag, ".out_acc12"},   32'(out_acc12),   32'(m_acc12));
        chk({tag, ".out_ovf12"},   32'(out_ovf12),   32'(m_ovf12));
        chk({tag, ".in_ready6"},   32'(in_ready6),   32'(!m_hold));
        chk({tag, ".out_valid6"},  32'(out_valid6),  32'(m_valid));
        chk({tag, ".out_acc6"},    32'(out_acc6),    32'(m_acc6));
        chk({tag, ".out_ovf6"},    32'(out_ovf6),    32'(m_ovf6));
    endtask

    task automatic step(input string tag, input bit iv, input int s, input bit clr, input bit ordy);
        in_valid  = iv;
        in_sum    = 5'(s);
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, s, clr, ordy);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        #2;
        rst_n = 1'b1;

        // 8 x 8 back to back, sink always ready: total 64
        for (int i = 0; i < N; i++) step("b64", 1'b1, 8, 1'b0, 1'b1);
        chk("b64.total", 32'(out_acc12), 32'd64);
        step("b64.drain", 1'b0, 0, 1'b0, 1'b1);
        step("b64.idle", 1'b0, 0, 1'b0, 1'b1);

        // in_valid every other cycle, values 1..8: total 36
        for (int i = 1; i <= N; i++) begin
            step("b36", 1'b1, i, 1'b0, 1'b1);
            step("b36.gap", 1'b0, 31, 1'b0, 1'b1);
        end
        chk("b36.total", 32'(out_acc12), 32'd36);

        // 8 x 2 then 5 cycles of backpressure with in_valid pulses ignored
        for (int i = 0; i < N; i++) step("b16", 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("b16.hold", (i % 2) == 0, 7, 1'b0, 1'b0);
        chk("b16.total", 32'(out_acc12), 32'd16);
        step("b16.take", 1'b1, 9, 1'b0, 1'b1);
        step("b16.idle", 1'b0, 0, 1'b0, 1'b1);

        // 8 x 31: 248 fits 12 bits, overflows the 6-bit instance
        for (int i = 0; i < N; i++) step("b248", 1'b1, 31, 1'b0, 1'b1);
`ifdef SUM_ACC_SAT_EN
        chk("b248.acc6", 32'(out_acc6), 32'd63);
`else
        chk("b248.acc6", 32'(out_acc6), 32'd56);
`endif
        chk("b248.ovf6", 32'(out_ovf6), 32'd1);
        step("b248.drain", 1'b0, 0, 1'b0, 1'b1);

        // clear after 3 accepts, clear carries a sample that must be dropped
        for (int i = 0; i < 3; i++) step("clr.pre", 1'b1, 10, 1'b0, 1'b1);
        step("clr.hit", 1'b1, 10, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) step("b24", 1'b1, 3, 1'b0, 1'b1);
        chk("b24.total", 32'(out_acc12), 32'd24);
        step("b24.drain", 1'b0, 0, 1'b0, 1'b1);

        // clear while a result is pending drops it even with out_ready high
        for (int i = 0; i < N; i++) step("clrh", 1'b1, 4, 1'b0, 1'b0);
        step("clrh.hit", 1'b0, 0, 1'b1, 1'b1);

        // async reset mid-cycle while holding a 64 result
        for (int i = 0; i < N; i++) step("rst.b64", 1'b1, 8, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) step("b40", 1'b1, 5, 1'b0, 1'b1);
        chk("b40.total", 32'(out_acc12), 32'd40);
        step("b40.drain", 1'b0, 0, 1'b0, 1'b1);

        // random traffic with occasional clears and backpressure
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 31),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
